dsp_ch_addr_split: RTL and testbench
====================================

// Module: dsp_ch_addr_split
// PURPOSE
//  Inverse of the per-channel address adder. Accepts a global burst request (64-bit byte address + beat count).
//  Decodes the channel index from the address and strips the channel offset back out. Splits a burst that crosses
//  a channel boundary into two sub-bursts and routes each to its channel's request port with valid/ready.
//  Sits between the merge-tree read/write issuers and the per-channel memory request queues.
// PARAMETERS
//  NUM_CH      32   number of channels, 1..32; channel field is 5 bits wide
//  CH_SHIFT    28   bit position of channel field (channel span = 2^CH_SHIFT bytes)
//  LEN_W       8    width of beat count (len = beats-1, AXI style)
//  BEAT_BYTES  64   bytes per beat, power of 2; addresses must be BEAT_BYTES aligned
// PORTS
//  aclk         in   1        clock
//  areset       in   1        synchronous active-high reset
//  s_valid      in   1        request valid
//  s_ready      out  1        request accepted when s_valid&s_ready
//  s_addr       in   64       global byte address
//  s_len        in   LEN_W    beats-1
//  m_valid      out  NUM_CH   one-hot per-channel request valid
//  m_ready      in   NUM_CH   per-channel ready
//  m_addr       out  64       channel-local address (channel field cleared)
//  m_len        out  LEN_W    beats-1 of this sub-burst
//  m_ch         out  5        decoded channel index of current sub-burst
//  m_split      out  1        1 = sub-burst is part of a split request
//  err          out  1        1-cycle pulse: request/sub-burst dropped
//  err_cnt      out  16       saturating count of err pulses
// BEHAVIOUR
//  - Decode: ch = s_addr[CH_SHIFT+:5].
//  - m_addr = {s_addr[63:CH_SHIFT+5], 5'b0, s_addr[CH_SHIFT-1:0]}. High bits pass through unchanged.
//  - Split check: off = s_addr[CH_SHIFT-1:0]; bytes = (s_len+1)*BEAT_BYTES; split iff off+bytes > 2^CH_SHIFT.
//    A split is never more than two parts, because bytes is at most 2^CH_SHIFT.
//  - Split lengths: lenA = (2^CH_SHIFT-off)/BEAT_BYTES - 1; lenB = s_len - lenA - 1.
//  - Split addresses: part B is on ch+1, at m_addr with low CH_SHIFT bits = 0.
//  - Errors, each producing an err pulse and err_cnt+1 (saturating at 16'hFFFF):
//    ch >= NUM_CH, or address misaligned: request accepted, dropped, no m_valid.
//    Split with ch+1 >= NUM_CH: part A issued, part B dropped; err pulses on the cycle part B would have issued.
//  - FSM states IDLE, ISSUE_A, ISSUE_B:
//    IDLE: s_ready=1. On accept -> ISSUE_A if valid, else stay in IDLE and pulse err next cycle.
//    ISSUE_A: m_valid[ch]=1. On m_ready[ch]: if split -> ISSUE_B, else -> IDLE or ISSUE_A (new accept).
//    ISSUE_B: m_valid[ch+1]=1. On m_ready[ch+1] -> IDLE or ISSUE_A (new accept).
//  - s_ready = IDLE | (ISSUE_A & ~split & m_ready[ch]) | (ISSUE_B & m_ready[ch+1]).
//    Full throughput: one unsplit request per cycle.
//  - Latency: request accepted at cycle N -> m_valid at N+1 (one register stage). No combinational s->m path.
//  - m_valid is never deasserted without handshake. m_addr/m_len/m_ch/m_split are held stable while
//    valid & ~ready. At most one m_valid bit is set at any time.
//  - Reset (any state, including mid-split): state=IDLE, m_valid=0, m_addr/m_len/m_ch=0, m_split=0,
//    err=0, err_cnt=0. A pending part B is discarded. s_ready=1 on the first cycle after reset deasserts.
// TESTING (NUM_CH=32 unless noted, CH_SHIFT=28, BEAT_BYTES=64)
//  1 addr=0x0000_0000_3000_1000,len=15 -> next cycle m_valid=1<<3, m_addr=0x1000, m_len=15, m_ch=3, m_split=0
//  2 addr=0x0000_0000_3FFF_FF00,len=7 -> ch3 addr 0x0FFF_FF00 len3 split=1, then ch4 addr 0x0 len3 split=1
//  3 NUM_CH=16, addr=0x0000_0001_2000_0000 -> no m_valid, err pulses once, err_cnt=1, s_ready stays 1
//  4 case 1 with m_ready[3]=0 for 5 cycles -> m_* stable, s_ready=0 throughout; handshake on release
//  5 4 unsplit requests back-to-back, m_ready=all 1 -> 4 consecutive m_valid cycles, s_ready constant 1
//  6 areset=1 while in ISSUE_B of case 2 -> next cycle m_valid=0, err_cnt=0; part B never issued

Source files
------------

// File: rtl/dsp_ch_addr_split.sv
// dsp_ch_addr_split
// Takes a global burst request, decodes the channel from the address and
// clears the channel field. A burst that runs past the end of its channel
// window is cut into two sub-bursts, and the second goes to the next channel.
// Each sub-burst leaves on a registered valid/ready port for its channel.
// Requests that cannot be routed are dropped, reported with a 1-cycle err
// pulse, and counted in a saturating error counter.
module dsp_ch_addr_split #(
    parameter int NUM_CH     = 32,
    parameter int CH_SHIFT   = 28,
    parameter int LEN_W      = 8,
    parameter int BEAT_BYTES = 64
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [63:0]       s_addr,
    input  logic [LEN_W-1:0]  s_len,
    output logic [NUM_CH-1:0] m_valid,
    input  logic [NUM_CH-1:0] m_ready,
    output logic [63:0]       m_addr,
    output logic [LEN_W-1:0]  m_len,
    output logic [4:0]        m_ch,
    output logic              m_split,
    output logic              err,
    output logic [15:0]       err_cnt
);

    localparam int BSH = $clog2(BEAT_BYTES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_A = 2'd1,
        ISSUE_B = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;

    logic [NUM_CH-1:0]  m_valid_r;
    logic [63:0]        m_addr_r;
    logic [LEN_W-1:0]   m_len_r;
    logic [4:0]         m_ch_r;
    logic               split_r;
    logic               b_ok_r;
    logic [LEN_W-1:0]   len_b_r;
    logic               err_r;
    logic [15:0]        err_cnt_r;

    logic [4:0]         req_ch_s;
    logic [CH_SHIFT-1:0] req_off_s;
    logic [63:0]        req_local_s;
    logic [63:0]        req_end_s;
    logic               req_bad_s;
    logic               req_split_s;
    logic               req_b_ok_s;
    logic [LEN_W-1:0]   req_len_a_s;
    logic [LEN_W-1:0]   req_len_b_s;

    logic               cur_ready_s;
    logic               s_ready_s;
    logic               accept_s;
    logic               load_a_s;
    logic               load_b_s;
    logic               err_set_s;

    // Decode the incoming request: channel, local address, validity and split lengths.
    always_comb begin
        req_ch_s    = s_addr[CH_SHIFT +: 5];
        req_off_s   = s_addr[CH_SHIFT-1:0];
        req_local_s = {s_addr[63:CH_SHIFT+5], 5'b00000, s_addr[CH_SHIFT-1:0]};
        req_bad_s   = ({1'b0, req_ch_s} >= 6'(NUM_CH)) || (s_addr[BSH-1:0] != '0);
        // End of the burst relative to the window start; beyond 2^CH_SHIFT means it spills over.
        req_end_s   = 64'(req_off_s) + ((64'(s_len) + 64'd1) << BSH);
        req_split_s = req_end_s > (64'd1 << CH_SHIFT);
        req_b_ok_s  = ({1'b0, req_ch_s} + 6'd1) < 6'(NUM_CH);
        // Offset is beat aligned, so (2^CH_SHIFT - off)/BEAT - 1 is just the inverted offset in beats.
        req_len_a_s = LEN_W'((~req_off_s) >> BSH);
        req_len_b_s = s_len - req_len_a_s - LEN_W'(1);
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !req_bad_s) state_nx_s = ISSUE_A;
                else                        state_nx_s = IDLE;
            end
            ISSUE_A: begin
                if (cur_ready_s) begin
                    if (split_r)                     state_nx_s = b_ok_r ? ISSUE_B : IDLE;
                    else if (accept_s && !req_bad_s) state_nx_s = ISSUE_A;
                    else                             state_nx_s = IDLE;
                end else begin
                    state_nx_s = ISSUE_A;
                end
            end
            ISSUE_B: begin
                if (cur_ready_s) begin
                    if (accept_s && !req_bad_s) state_nx_s = ISSUE_A;
                    else                        state_nx_s = IDLE;
                end else begin
                    state_nx_s = ISSUE_B;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake and control decode: upstream ready, load strobes, error strobe.
    always_comb begin
        cur_ready_s = |(m_valid_r & m_ready);
        s_ready_s   = 1'b0;
        case (state_r)
            IDLE:    s_ready_s = 1'b1;
            ISSUE_A: s_ready_s = !split_r && cur_ready_s;
            ISSUE_B: s_ready_s = cur_ready_s;
            default: s_ready_s = 1'b0;
        endcase
        accept_s  = s_valid && s_ready_s;
        load_a_s  = accept_s && !req_bad_s;
        load_b_s  = (state_r == ISSUE_A) && cur_ready_s && split_r && b_ok_r;
        // A dropped part B is reported in the cycle it would have been valid.
        err_set_s = (accept_s && req_bad_s) ||
                    ((state_r == ISSUE_A) && cur_ready_s && split_r && !b_ok_r);
    end

    // Registered sub-burst outputs and error reporting.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_valid_r <= '0;
            m_addr_r  <= 64'd0;
            m_len_r   <= '0;
            m_ch_r    <= 5'd0;
            split_r   <= 1'b0;
            b_ok_r    <= 1'b0;
            len_b_r   <= '0;
            err_r     <= 1'b0;
            err_cnt_r <= 16'd0;
        end else begin
            if (load_a_s) begin
                m_valid_r <= NUM_CH'(1) << req_ch_s;
                m_addr_r  <= req_local_s;
                m_len_r   <= req_split_s ? req_len_a_s : s_len;
                m_ch_r    <= req_ch_s;
                split_r   <= req_split_s;
                b_ok_r    <= req_b_ok_s;
                len_b_r   <= req_len_b_s;
            end else if (load_b_s) begin
                // Part B starts at the base of the next channel window; channel field is already clear.
                m_valid_r <= m_valid_r << 1;
                m_addr_r  <= {m_addr_r[63:CH_SHIFT], {CH_SHIFT{1'b0}}};
                m_len_r   <= len_b_r;
                m_ch_r    <= m_ch_r + 5'd1;
            end else if (cur_ready_s) begin
                m_valid_r <= '0;
            end
            err_r <= err_set_s;
            if (err_set_s && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_r;
    assign m_addr  = m_addr_r;
    assign m_len   = m_len_r;
    assign m_ch    = m_ch_r;
    assign m_split = split_r;
    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_dsp_ch_addr_split.sv
// Testbench for dsp_ch_addr_split: directed cases followed by randomized
// traffic, all checked against a queue-based model of the expected sub-bursts.
module tb_dsp_ch_addr_split;

    localparam int NUM_CH = 16;

    logic              aclk = 1'b0;
    logic              areset;
    logic              s_valid;
    logic              s_ready;
    logic [63:0]       s_addr;
    logic [7:0]        s_len;
    logic [NUM_CH-1:0] m_valid;
    logic [NUM_CH-1:0] m_ready;
    logic [63:0]       m_addr;
    logic [7:0]        m_len;
    logic [4:0]        m_ch;
    logic              m_split;
    logic              err;
    logic [15:0]       err_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [4:0]  ch;
        logic [63:0] addr;
        logic [7:0]  len;
        logic        split;
        logic        drop;
    } item_t;

    item_t q[$];
    logic  mon_en    = 1'b0;
    logic  exp_err_nx = 1'b0;
    int    exp_cnt   = 0;

    dsp_ch_addr_split #(
        .NUM_CH(NUM_CH), .CH_SHIFT(28), .LEN_W(8), .BEAT_BYTES(64)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_len(s_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_len(m_len),
        .m_ch(m_ch), .m_split(m_split), .err(err), .err_cnt(err_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: turn one accepted request into expected sub-bursts, or flag an error.
    task automatic model_accept(input logic [63:0] a, input logic [7:0] len, output logic nerr);
        longint unsigned off, bytes, len_a, span;
        int              ch;
        logic [63:0]     local_a;
        item_t           it;
        span    = 64'd1 << 28;
        ch      = int'(a[32:28]);
        off     = longint'(a[27:0]);
        bytes   = (longint'(len) + 1) * 64;
        local_a = a;
        local_a[32:28] = 5'd0;
        nerr    = 1'b0;
        if ((a[5:0] != 6'd0) || (ch >= NUM_CH)) begin
            nerr = 1'b1;
        end else if (off + bytes > span) begin
            len_a    = (span - off) / 64 - 1;
            it.ch    = 5'(ch);
            it.addr  = local_a;
            it.len   = 8'(len_a);
            it.split = 1'b1;
            it.drop  = (ch + 1 >= NUM_CH);
            q.push_back(it);
            if (ch + 1 < NUM_CH) begin
                it.ch    = 5'(ch + 1);
                it.addr  = {a[63:33], 33'd0};
                it.len   = 8'(longint'(len) - len_a - 1);
                it.split = 1'b1;
                it.drop  = 1'b0;
                q.push_back(it);
            end
        end else begin
            it.ch    = 5'(ch);
            it.addr  = local_a;
            it.len   = len;
            it.split = 1'b0;
            it.drop  = 1'b0;
            q.push_back(it);
        end
    endtask

    // Cycle monitor: compares every output against the model, then advances it.
    always @(negedge aclk) begin
        if (mon_en) begin
            logic hs, exp_rdy, nerr;
            check_eq("err", 64'(err), 64'(exp_err_nx));
            if (exp_err_nx && exp_cnt < 65535) exp_cnt++;
            check_eq("err_cnt", 64'(err_cnt), 64'(exp_cnt));
            hs      = |(m_valid & m_ready);
            exp_rdy = (q.size() == 0) || ((q.size() == 1) && hs && !q[0].drop);
            check_eq("s_ready", 64'(s_ready), 64'(exp_rdy));
            if (q.size() == 0) begin
                check_eq("m_valid_idle", 64'(m_valid), 64'd0);
            end else begin
                check_eq("m_valid", 64'(m_valid), 64'(NUM_CH'(1) << q[0].ch));
                check_eq("m_addr", m_addr, q[0].addr);
                check_eq("m_len", 64'(m_len), 64'(q[0].len));
                check_eq("m_ch", 64'(m_ch), 64'(q[0].ch));
                check_eq("m_split", 64'(m_split), 64'(q[0].split));
            end
            nerr = 1'b0;
            if (hs && q.size() > 0) begin
                nerr = q[0].drop;
                void'(q.pop_front());
            end
            if (s_valid && s_ready) begin
                logic e;
                model_accept(s_addr, s_len, e);
                nerr = nerr | e;
            end
            exp_err_nx = nerr;
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [63:0] a, input logic [7:0] l);
        s_valid = v;
        s_addr  = a;
        s_len   = l;
    endtask

    initial begin
        logic [63:0] ra;
        logic [27:0] off;
        areset  = 1'b1;
        m_ready = '0;
        set_req(1'b0, 64'd0, 8'd0);
        repeat (3) cyc();
        areset = 1'b0;
        mon_en = 1'b1;
        cyc();

        // Plain request to channel 3.
        m_ready = '1;
        set_req(1'b1, 64'h0000_0000_3000_1000, 8'd15);
        cyc();
        s_valid = 1'b0;
        @(negedge aclk);
        check_eq("t1_valid", 64'(m_valid), 64'h8);
        check_eq("t1_addr", m_addr, 64'h1000);
        check_eq("t1_len", 64'(m_len), 64'd15);
        check_eq("t1_split", 64'(m_split), 64'd0);
        cyc();

        // Burst crossing from channel 3 into channel 4.
        set_req(1'b1, 64'h0000_0000_3FFF_FF00, 8'd7);
        cyc();
        s_valid = 1'b0;
        @(negedge aclk);
        check_eq("t2a_ch", 64'(m_ch), 64'd3);
        check_eq("t2a_addr", m_addr, 64'h0FFF_FF00);
        check_eq("t2a_len", 64'(m_len), 64'd3);
        check_eq("t2a_split", 64'(m_split), 64'd1);
        cyc();
        @(negedge aclk);
        check_eq("t2b_valid", 64'(m_valid), 64'h10);
        check_eq("t2b_addr", m_addr, 64'h0);
        check_eq("t2b_len", 64'(m_len), 64'd3);
        check_eq("t2b_split", 64'(m_split), 64'd1);
        cyc();

        // Channel beyond NUM_CH is dropped with an error.
        set_req(1'b1, 64'h0000_0001_2000_0000, 8'd0);
        cyc();
        s_valid = 1'b0;
        @(negedge aclk);
        check_eq("t3_valid", 64'(m_valid), 64'd0);
        check_eq("t3_err", 64'(err), 64'd1);
        check_eq("t3_cnt", 64'(err_cnt), 64'd1);
        check_eq("t3_rdy", 64'(s_ready), 64'd1);
        cyc();
        @(negedge aclk);
        check_eq("t3_err_off", 64'(err), 64'd0);
        cyc();

        // Backpressure on channel 3 for five cycles.
        m_ready = '0;
        set_req(1'b1, 64'h0000_0000_3000_1000, 8'd15);
        cyc();
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check_eq("t4_rdy", 64'(s_ready), 64'd0);
            check_eq("t4_addr", m_addr, 64'h1000);
            check_eq("t4_valid", 64'(m_valid), 64'h8);
            cyc();
        end
        m_ready = '1;
        @(negedge aclk);
        check_eq("t4_release_rdy", 64'(s_ready), 64'd1);
        cyc();

        // Four unsplit requests back to back.
        set_req(1'b1, 64'h0000_0000_1000_0000, 8'd0);
        cyc();
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) set_req(1'b1, 64'h0000_0000_1000_0000 + 64'(i) * 64'h1000_0000, 8'd0);
            else       s_valid = 1'b0;
            @(negedge aclk);
            check_eq("t5_valid", 64'(m_valid), 64'(NUM_CH'(1) << i));
            check_eq("t5_rdy", 64'(s_ready), 64'd1);
            cyc();
        end

        // Reset while part B of a split is pending.
        set_req(1'b1, 64'h0000_0000_3FFF_FF00, 8'd7);
        cyc();
        s_valid = 1'b0;
        cyc();
        m_ready    = '0;
        areset     = 1'b1;
        mon_en     = 1'b0;
        q.delete();
        exp_err_nx = 1'b0;
        exp_cnt    = 0;
        cyc();
        @(negedge aclk);
        check_eq("t6_valid", 64'(m_valid), 64'd0);
        check_eq("t6_cnt", 64'(err_cnt), 64'd0);
        check_eq("t6_addr", m_addr, 64'd0);
        check_eq("t6_split", 64'(m_split), 64'd0);
        cyc();
        areset  = 1'b0;
        m_ready = '1;
        mon_en  = 1'b1;
        repeat (4) cyc();

        // Randomized traffic, biased toward channel-boundary crossings.
        for (int n = 0; n < 3000; n++) begin
            off = 28'($urandom) & 28'hFFF_FFC0;
            case ($urandom_range(0, 2))
                0:       off = 28'h000_0000 - 28'(64 * $urandom_range(1, 300));
                1:       off = off & 28'h000_3FC0;
                default: off = off;
            endcase
            ra = {$urandom, $urandom};
            ra[32:28] = 5'($urandom_range(0, 19));
            ra[27:0]  = off;
            if ($urandom_range(0, 15) == 0) ra[5:0] = 6'd8;
            set_req($urandom_range(0, 9) < 7, ra, 8'($urandom));
            m_ready = NUM_CH'($urandom) | NUM_CH'($urandom);
            cyc();
        end
        s_valid = 1'b0;
        m_ready = '1;
        repeat (10) cyc();
        check_eq("drain", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
